// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch/redirect slice: address width,
// instruction width, reset PC and the fetch request FSM encoding.
package fetch_pkg;

  localparam int                DEFAULT_XLEN       = 64;
  localparam int                INST_W             = 32;
  localparam int                DEFAULT_IBUF_DEPTH = 2;
  localparam logic [63:0]       DEFAULT_RESET_PC   = 64'h0;

  // REQ: may issue a fetch; WAIT: live response due; SQUASH: stale response due.
  typedef enum logic [1:0] {
    REQ    = 2'd0,
    WAIT   = 2'd1,
    SQUASH = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_ibuf.sv
// Synchronous FIFO holding fetched {pc, instruction} entries for decode.
// Flush empties it in one cycle and takes priority over push and pop.
module fetch_ibuf #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; count/empty qualify every read, so contents never need clearing.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_redirect_unit.sv
// Fetch PC owner: issues sequential imem requests (one outstanding), buffers
// responses for decode and redirects/flushes/squashes on a taken branch.
module fetch_redirect_unit
  import fetch_pkg::*;
#(
  parameter int               XLEN       = DEFAULT_XLEN,
  parameter logic [XLEN-1:0]  RESET_PC   = XLEN'(DEFAULT_RESET_PC),
  parameter int               IBUF_DEPTH = DEFAULT_IBUF_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              take_branch,
  input  logic [XLEN-1:0]   branch_target,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [XLEN-1:0]   inst_pc,
  output logic [INST_W-1:0] inst_data,
  output logic              misaligned
);

  localparam int ENTRY_W = XLEN + INST_W;
  localparam int CNT_W   = $clog2(IBUF_DEPTH + 1);

  fetch_state_t        state;
  fetch_state_t        state_nxt;
  logic [XLEN-1:0]     pc;
  logic [XLEN-1:0]     req_pc;
  logic                misaligned_q;
  logic                issue;
  logic                accept;
  logic                push;
  logic                pop;
  logic [ENTRY_W-1:0]  head;
  logic [CNT_W-1:0]    count;
  logic                full;
  logic                empty;

  // The buffer-space guard on issue is what makes a push into a full buffer impossible.
  assign issue          = (state == REQ) && (count < CNT_W'(IBUF_DEPTH));
  assign imem_req_valid = issue & ~reset;
  assign imem_req_addr  = pc;
  assign accept         = imem_req_valid & imem_req_ready;

  assign push       = (state == WAIT) & imem_rsp_valid & ~take_branch;
  assign pop        = inst_valid & inst_ready & ~take_branch;
  assign inst_valid = ~empty & ~reset;
  assign misaligned = misaligned_q & ~reset;
  assign {inst_pc, inst_data} = head;

  fetch_ibuf #(
    .WIDTH (ENTRY_W),
    .DEPTH (IBUF_DEPTH)
  ) u_ibuf (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (take_branch),
    .wdata ({req_pc, imem_rsp_data}),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // NOTE: defaults assigned first so every path drives state_nxt and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      REQ:     if (accept) state_nxt = take_branch ? SQUASH : WAIT;
      WAIT:    if (imem_rsp_valid) state_nxt = REQ;
               else if (take_branch) state_nxt = SQUASH;
      SQUASH:  if (imem_rsp_valid) state_nxt = REQ;
      default: state_nxt = REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= REQ;
      pc           <= RESET_PC;
      req_pc       <= RESET_PC;
      misaligned_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      misaligned_q <= take_branch & (|branch_target[1:0]);
      if (accept) req_pc <= pc;
      if (take_branch)  pc <= {branch_target[XLEN-1:2], 2'b00};
      else if (accept)  pc <= pc + XLEN'(4);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && full && !pop));

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Randomized bench: a responding imem, random redirects/stalls/resets, and a
// queue-based reference model of fetch PC, outstanding request and buffer.
module tb_fetch_redirect_unit;
  import fetch_pkg::*;

  localparam int          XLEN   = 64;
  localparam int          DEPTH  = 2;
  localparam logic [63:0] RST_PC = 64'h0;
  localparam int          CYCLES = 4000;

  logic              clk;
  logic              reset;
  logic              take_branch;
  logic [XLEN-1:0]   branch_target;
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [XLEN-1:0]   imem_req_addr;
  logic              imem_rsp_valid;
  logic [INST_W-1:0] imem_rsp_data;
  logic              inst_valid;
  logic              inst_ready;
  logic [XLEN-1:0]   inst_pc;
  logic [INST_W-1:0] inst_data;
  logic              misaligned;

  fetch_redirect_unit #(
    .XLEN       (XLEN),
    .RESET_PC   (RST_PC),
    .IBUF_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .take_branch    (take_branch),
    .branch_target  (branch_target),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_pc        (inst_pc),
    .inst_data      (inst_data),
    .misaligned     (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: fetch PC, whether a request is in flight and whether its
  // answer is already unwanted, plus the instruction buffer as a queue.
  typedef struct {
    logic [63:0] pc;
    logic [31:0] data;
  } entry_t;

  entry_t      m_buf[$];
  logic [63:0] m_pc;
  logic [63:0] m_req_pc;
  bit          m_out;
  bit          m_stale;
  bit          m_mis;

  // Behavioural imem: one slot, answers 1..3 cycles after acceptance and
  // refuses new requests while an answer is still owed.
  bit          im_pending;
  int          im_delay;
  logic [31:0] im_data;

  function automatic logic [63:0] pick_target();
    logic [63:0] t;
    if ($urandom_range(9) == 0) t = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15));
    else                        t = {48'h0, 16'($urandom)};
    if ($urandom_range(2) != 0) t[1:0] = 2'b00;
    return t;
  endfunction

  task automatic run_cycle(input bit rst, input int p_br, input int p_rdy, input int p_irdy);
    bit exp_rv, exp_iv, exp_mis, acc, rsp;
    @(negedge clk);
    reset          = rst;
    imem_rsp_valid = im_pending && (im_delay == 0);
    imem_rsp_data  = imem_rsp_valid ? im_data : $urandom;
    imem_req_ready = !im_pending && ($urandom_range(99) < p_rdy);
    take_branch    = ($urandom_range(99) < p_br);
    branch_target  = pick_target();
    inst_ready     = ($urandom_range(99) < p_irdy);
    #1;

    exp_rv  = !rst && !m_out && (m_buf.size() < DEPTH);
    exp_iv  = !rst && (m_buf.size() > 0);
    exp_mis = !rst && m_mis;
    check("req_valid", 64'(imem_req_valid), 64'(exp_rv));
    if (exp_rv) check("req_addr", imem_req_addr, m_pc);
    check("inst_valid", 64'(inst_valid), 64'(exp_iv));
    if (exp_iv) begin
      check("inst_pc", inst_pc, m_buf[0].pc);
      check("inst_data", 64'(inst_data), 64'(m_buf[0].data));
    end
    check("misaligned", 64'(misaligned), 64'(exp_mis));

    acc = exp_rv && imem_req_ready;
    if (rst) begin
      m_pc = RST_PC; m_out = 0; m_stale = 0; m_mis = 0;
      m_buf.delete();
    end else begin
      rsp = imem_rsp_valid && m_out;
      if (take_branch) begin
        m_pc  = {branch_target[63:2], 2'b00};
        m_mis = |branch_target[1:0];
        m_buf.delete();
        if (acc) begin
          m_out = 1; m_stale = 1;
        end else if (m_out) begin
          if (rsp) begin m_out = 0; m_stale = 0; end
          else m_stale = 1;
        end
      end else begin
        m_mis = 0;
        if (exp_iv && inst_ready) void'(m_buf.pop_front());
        if (rsp) begin
          if (!m_stale) m_buf.push_back('{m_req_pc, imem_rsp_data});
          m_out = 0; m_stale = 0;
        end
        if (acc) begin
          m_req_pc = m_pc; m_pc = m_pc + 64'd4; m_out = 1; m_stale = 0;
        end
      end
    end

    if (imem_rsp_valid)  im_pending = 0;
    else if (im_pending) im_delay--;
    if (acc) begin
      im_pending = 1;
      im_delay   = $urandom_range(2);
      im_data    = $urandom;
    end
  endtask

  initial begin
    int p_br, p_rdy, p_irdy;
    reset = 1'b1; take_branch = 1'b0; branch_target = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    inst_ready = 1'b0;
    m_pc = RST_PC; m_req_pc = RST_PC; m_out = 0; m_stale = 0; m_mis = 0;
    im_pending = 0; im_delay = 0; im_data = '0;

    for (int i = 0; i < 3; i++) run_cycle(1'b1, 0, 100, 100);
    // Straight-line fetch with an always-ready imem and decode.
    for (int i = 0; i < 20; i++) run_cycle(1'b0, 0, 100, 100);

    for (int cyc = 0; cyc < CYCLES; cyc++) begin
      case ((cyc / 400) % 4)
        0:       begin p_br = 4;  p_rdy = 90; p_irdy = 95; end
        1:       begin p_br = 3;  p_rdy = 80; p_irdy = 10; end
        2:       begin p_br = 25; p_rdy = 60; p_irdy = 70; end
        default: begin p_br = 10; p_rdy = 50; p_irdy = 50; end
      endcase
      run_cycle($urandom_range(199) == 0, p_br, p_rdy, p_irdy);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
